// File: rtl/lsu_pipe_if.sv
// Instruction-side handshake plus memory-bus signals of the load/store unit.
// "slave" is the view taken by lsu_pipe; "master" is the view taken by the core/memory environment.
interface lsu_pipe_if #(
  parameter int XLEN = 64
) ();
  localparam int STRB_W = XLEN / 8;

  logic              in_valid;
  logic              in_ready;
  logic              load_en;
  logic              store_en;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   store_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   load_data;
  logic              err;
  logic              mm_req;
  logic              mm_gnt;
  logic              mm_we;
  logic [XLEN-1:0]   mm_addr;
  logic [XLEN-1:0]   mm_wdata;
  logic [STRB_W-1:0] mm_wstrb;
  logic              mm_rvalid;
  logic [XLEN-1:0]   mm_rdata;

  modport slave (
    input  in_valid, load_en, store_en, funct3, addr, store_data, out_ready,
    input  mm_gnt, mm_rvalid, mm_rdata,
    output in_ready, out_valid, load_data, err,
    output mm_req, mm_we, mm_addr, mm_wdata, mm_wstrb
  );

  modport master (
    output in_valid, load_en, store_en, funct3, addr, store_data, out_ready,
    output mm_gnt, mm_rvalid, mm_rdata,
    input  in_ready, out_valid, load_data, err,
    input  mm_req, mm_we, mm_addr, mm_wdata, mm_wstrb
  );
endinterface

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store unit: byte-lane steering, strobes, load extension, fault reporting.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault accesses whose offset is not size-aligned.
module lsu_pipe #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input logic       clk,
  input logic       rst,
  lsu_pipe_if.slave bus
);
  localparam int OFF_W = $clog2(STRB_W);
  localparam int SH_W  = OFF_W + 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;

  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [XLEN-1:0] res_q;
  logic            err_q;

  logic             is_mem;
  logic             fault_in;
  logic [OFF_W-1:0] off_q;
  logic [SH_W-1:0]  sh_q;
  logic [XLEN-1:0]  ld_word;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
    logic [7:0] low;
    low = 8'((8'd1 << f3[1:0]) - 8'd1);
    return ((8'(off) & low) != 8'h00);
  endfunction
`endif

  // Signed locals make the size casts below sign-extend; unsigned slices zero-extend.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [XLEN-1:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    b = w[7:0];
    h = w[15:0];
    s = w[31:0];
    case (f3)
      3'b000:  return XLEN'(b);
      3'b001:  return XLEN'(h);
      3'b010:  return XLEN'(s);
      3'b100:  return XLEN'(w[7:0]);
      3'b101:  return XLEN'(w[15:0]);
      3'b110:  return XLEN'(w[31:0]);
      3'b011:  return w;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    is_mem   = bus.load_en | bus.store_en;
    fault_in = illegal_f3(bus.funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    fault_in = fault_in | misaligned(bus.funct3, bus.addr[OFF_W-1:0]);
`endif
  end

  assign off_q   = addr_q[OFF_W-1:0];
  assign sh_q    = {off_q, 3'b000};
  assign ld_word = bus.mm_rdata >> sh_q;

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.mm_req    = 1'b0;
    bus.mm_we     = 1'b0;
    bus.mm_addr   = '0;
    bus.mm_wdata  = '0;
    bus.mm_wstrb  = '0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = (is_mem && !fault_in) ? REQ : DONE;
      end
      REQ: begin
        // Bus fields come straight from the latched operands, so they cannot move before the grant.
        bus.mm_req   = 1'b1;
        bus.mm_we    = we_q;
        bus.mm_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        bus.mm_wdata = sdata_q << sh_q;
        bus.mm_wstrb = STRB_W'(size_mask(f3_q[1:0])) << off_q;
        if (bus.mm_gnt) state_n = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (bus.mm_rvalid) state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.load_data = res_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        res_q <= '0;
        err_q <= is_mem & fault_in;
      end
      if (state == WAIT && bus.mm_rvalid) res_q <= extract(f3_q, ld_word);
    end
  end

  // Operand capture at accept; only observed while in REQ/WAIT.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      we_q    <= bus.store_en & ~bus.load_en;
      f3_q    <= bus.funct3;
      addr_q  <= bus.addr;
      sdata_q <= bus.store_data;
    end
  end
endmodule
